dircc_node_multi_timer: RTL and testbench



---
 rtl/dircc_timer_pkg.sv | 29 ++
 rtl/dircc_timer_channel.sv | 107 ++++++++++
 rtl/dircc_node_multi_timer.sv | 116 +++++++++++
 tb/tb_dircc_node_multi_timer.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dircc_timer_pkg.sv
// Shared constants for the multi-channel node timer: register word offsets,
// control bit positions and the channel-index width helper.
package dircc_timer_pkg;

  // Per-channel word offsets (address[CH_BITS+2] == 0)
  localparam logic [1:0] WordStatus   = 2'd0;
  localparam logic [1:0] WordControl  = 2'd1;
  localparam logic [1:0] WordPeriod   = 2'd2;
  localparam logic [1:0] WordSnapshot = 2'd3;

  // Global word offsets (address[CH_BITS+2] == 1)
  localparam logic [1:0] WordIrqPending = 2'd0;
  localparam logic [1:0] WordPrescale   = 2'd1;

  localparam int unsigned CtrlIto   = 0;
  localparam int unsigned CtrlCont  = 1;
  localparam int unsigned CtrlStart = 2;
  localparam int unsigned CtrlStop  = 3;

  localparam int unsigned PrescaleWidth = 16;

  function automatic int unsigned ch_bits(input int unsigned num_channels);
    if (num_channels <= 2) begin
      return 1;
    end
    return unsigned'($clog2(num_channels));
  endfunction

endpackage

// File: rtl/dircc_timer_channel.sv
// One timer channel: down-counter with period reload, one-shot/continuous
// control, sticky timeout with rising-edge detection, and snapshot capture.
module dircc_timer_channel
  import dircc_timer_pkg::*;
#(
  parameter int unsigned CounterWidth  = 32,
  parameter int unsigned DefaultPeriod = 49999
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    tick_i,
  input  logic                    wr_status_i,
  input  logic                    wr_control_i,
  input  logic                    wr_period_i,
  input  logic                    wr_snapshot_i,
  input  logic [CounterWidth-1:0] wdata_i,
  output logic [1:0]              status_o,
  output logic [3:0]              control_o,
  output logic [CounterWidth-1:0] period_o,
  output logic [CounterWidth-1:0] snapshot_o,
  output logic                    irq_pending_o
);

  localparam logic [CounterWidth-1:0] ResetPeriod = CounterWidth'(DefaultPeriod);

  logic [CounterWidth-1:0] counter_q, counter_d;
  logic [CounterWidth-1:0] period_q, period_d;
  logic [CounterWidth-1:0] snapshot_q, snapshot_d;
  logic [3:0]              control_q, control_d;
  logic                    running_q, running_d;
  logic                    timeout_q, timeout_d;
  logic                    force_reload_q, force_reload_d;
  logic                    zero_dly_q;

  logic zero, timeout_event, oneshot_done, start_wr, stop_wr;

  assign zero          = (counter_q == '0);
  assign timeout_event = zero & ~zero_dly_q;
  assign oneshot_done  = running_q & ~control_q[CtrlCont] & zero;
  assign start_wr      = wr_control_i & wdata_i[CtrlStart];
  assign stop_wr       = wr_control_i & wdata_i[CtrlStop];

  always_comb begin
    counter_d      = counter_q;
    period_d       = wr_period_i ? wdata_i : period_q;
    snapshot_d     = wr_snapshot_i ? counter_q : snapshot_q;
    control_d      = wr_control_i ? wdata_i[3:0] : control_q;
    force_reload_d = wr_period_i;

    if (force_reload_q) begin
      counter_d = period_q;
    end else if (running_q && tick_i) begin
      if (!zero) begin
        counter_d = counter_q - CounterWidth'(1);
      end else if (control_q[CtrlCont]) begin
        counter_d = period_q;
      end
      // One-shot at zero holds the counter at 0.
    end

    if (start_wr) begin
      running_d = 1'b1;
    end else if (stop_wr || force_reload_q || oneshot_done) begin
      running_d = 1'b0;
    end else begin
      running_d = running_q;
    end

    if (wr_status_i) begin
      timeout_d = 1'b0;
    end else if (timeout_event) begin
      timeout_d = 1'b1;
    end else begin
      timeout_d = timeout_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      counter_q      <= ResetPeriod;
      period_q       <= ResetPeriod;
      snapshot_q     <= '0;
      control_q      <= '0;
      running_q      <= 1'b0;
      timeout_q      <= 1'b0;
      force_reload_q <= 1'b0;
      // Matches the reset counter so no spurious edge follows reset release.
      zero_dly_q     <= (ResetPeriod == '0);
    end else begin
      counter_q      <= counter_d;
      period_q       <= period_d;
      snapshot_q     <= snapshot_d;
      control_q      <= control_d;
      running_q      <= running_d;
      timeout_q      <= timeout_d;
      force_reload_q <= force_reload_d;
      zero_dly_q     <= zero;
    end
  end

  assign status_o      = {running_q, timeout_q};
  assign control_o     = control_q;
  assign period_o      = period_q;
  assign snapshot_o    = snapshot_q;
  assign irq_pending_o = timeout_q & control_q[CtrlIto];

endmodule

// File: rtl/dircc_node_multi_timer.sv
// Multi-channel node timer: Avalon-MM decode, shared prescaler, per-channel
// timers, registered read mux and the combined interrupt line.
module dircc_node_multi_timer
  import dircc_timer_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS   = 4,
  parameter int unsigned COUNTER_WIDTH  = 32,
  parameter int unsigned DEFAULT_PERIOD = 49999,
  parameter int unsigned PRESCALE_RESET = 0,
  localparam int unsigned CH_BITS       = ch_bits(NUM_CHANNELS),
  localparam int unsigned AW            = CH_BITS + 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] address,
  input  logic          chipselect,
  input  logic          write_n,
  input  logic [31:0]   writedata,
  output logic [31:0]   readdata,
  output logic          irq
);

  logic               wr, glb_sel;
  logic [CH_BITS-1:0] ch_idx;
  logic [1:0]         word;

  assign wr      = chipselect & ~write_n;
  assign glb_sel = address[AW-1];
  assign ch_idx  = address[CH_BITS+1:2];
  assign word    = address[1:0];

  // Shared prescaler
  logic [PrescaleWidth-1:0] presc_q, presc_d, pcnt_q, pcnt_d;
  logic                     tick, wr_prescale;

  assign wr_prescale = wr & glb_sel & (ch_idx == '0) & (word == WordPrescale);
  assign tick        = (pcnt_q == presc_q);

  always_comb begin
    presc_d = wr_prescale ? writedata[PrescaleWidth-1:0] : presc_q;
    pcnt_d  = (wr_prescale || tick) ? '0 : pcnt_q + PrescaleWidth'(1);
  end

  logic [1:0]               ch_status   [NUM_CHANNELS];
  logic [3:0]               ch_control  [NUM_CHANNELS];
  logic [COUNTER_WIDTH-1:0] ch_period   [NUM_CHANNELS];
  logic [COUNTER_WIDTH-1:0] ch_snapshot [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  irq_pending;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_channel
    logic ch_wr;
    assign ch_wr = wr & ~glb_sel & (ch_idx == CH_BITS'(i));

    dircc_timer_channel #(
      .CounterWidth  (COUNTER_WIDTH),
      .DefaultPeriod (DEFAULT_PERIOD)
    ) u_channel (
      .clk_i         (clk),
      .rst_ni        (reset_n),
      .tick_i        (tick),
      .wr_status_i   (ch_wr & (word == WordStatus)),
      .wr_control_i  (ch_wr & (word == WordControl)),
      .wr_period_i   (ch_wr & (word == WordPeriod)),
      .wr_snapshot_i (ch_wr & (word == WordSnapshot)),
      .wdata_i       (writedata[COUNTER_WIDTH-1:0]),
      .status_o      (ch_status[i]),
      .control_o     (ch_control[i]),
      .period_o      (ch_period[i]),
      .snapshot_o    (ch_snapshot[i]),
      .irq_pending_o (irq_pending[i])
    );
  end

  // Read mux sampled every cycle; unmatched channels and words fall through to 0.
  logic [31:0] readdata_q, readdata_d;

  always_comb begin
    readdata_d = '0;
    if (glb_sel) begin
      if (ch_idx == '0) begin
        if (word == WordIrqPending) begin
          readdata_d = 32'(irq_pending);
        end else if (word == WordPrescale) begin
          readdata_d = 32'(presc_q);
        end
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        if (ch_idx == CH_BITS'(i)) begin
          case (word)
            WordStatus:   readdata_d = 32'(ch_status[i]);
            WordControl:  readdata_d = 32'(ch_control[i]);
            WordPeriod:   readdata_d = 32'(ch_period[i]);
            default:      readdata_d = 32'(ch_snapshot[i]);
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q    <= PrescaleWidth'(PRESCALE_RESET);
      pcnt_q     <= '0;
      readdata_q <= '0;
    end else begin
      presc_q    <= presc_d;
      pcnt_q     <= pcnt_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |irq_pending;

endmodule

// File: tb/tb_dircc_node_multi_timer.sv
// Directed bench for dircc_node_multi_timer with 3 channels, so channel
// index 3 exercises the unimplemented-channel path.
module tb_dircc_node_multi_timer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dircc_node_multi_timer #(
    .NUM_CHANNELS   (3),
    .COUNTER_WIDTH  (32),
    .DEFAULT_PERIOD (49999),
    .PRESCALE_RESET (7)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  function automatic logic [4:0] ca(input logic [1:0] ch, input logic [1:0] w);
    return {1'b0, ch, w};
  endfunction

  function automatic logic [4:0] ga(input logic [1:0] w);
    return {1'b1, 2'b00, w};
  endfunction

  // Tasks start and end on a falling edge; the rising edge in between acts.
  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(negedge clk);
    chipselect = 1'b0;
    d          = readdata;
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    n_cmp++;
    if (readdata !== 32'd0) begin
      $display("FAIL reset_readdata: got %0h want 0", readdata); n_err++;
    end
    n_cmp++;
    if (irq !== 1'b0) begin
      $display("FAIL reset_irq: got %b want 0", irq); n_err++;
    end
    reset_n = 1'b1;
    @(negedge clk);
    bus_read(ca(0, 2), rd);
    n_cmp++;
    if (rd !== 32'd49999) begin
      $display("FAIL reset_ch0_period: got %0d want 49999", rd); n_err++;
    end
    bus_read(ca(0, 0), rd);
    n_cmp++;
    if (rd !== 32'd0) begin
      $display("FAIL reset_ch0_status: got %0d want 0", rd); n_err++;
    end
    bus_read(ga(1), rd);
    n_cmp++;
    if (rd !== 32'd7) begin
      $display("FAIL reset_prescale: got %0d want 7", rd); n_err++;
    end
    bus_read(ca(0, 1), rd);
    n_cmp++;
    if (rd !== 32'd0) begin
      $display("FAIL reset_ch0_control: got %0d want 0", rd); n_err++;
    end
    bus_read(ca(2, 3), rd);
    n_cmp++;
    if (rd !== 32'd0) begin
      $display("FAIL reset_ch2_snapshot: got %0d want 0", rd); n_err++;
    end
  endtask

  task automatic test_continuous;
    int cnt;
    bus_write(ga(1), 32'd0);
    bus_write(ca(1, 2), 32'd5);
    bus_write(ca(1, 1), 32'h7);
    cnt = 0;
    while (irq !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    n_cmp++;
    if (cnt != 6) begin
      $display("FAIL cont_first_irq_latency: got %0d want 6", cnt); n_err++;
    end
    for (int k = 0; k < 2; k++) begin
      bus_write(ca(1, 0), 32'd0);
      n_cmp++;
      if (irq !== 1'b0) begin
        $display("FAIL cont_irq_cleared: got %b want 0", irq); n_err++;
      end
      cnt = 0;
      while (irq !== 1'b1 && cnt < 20) begin
        @(negedge clk);
        cnt++;
      end
      n_cmp++;
      if (cnt != 5) begin
        $display("FAIL cont_irq_recur: got %0d want 5", cnt); n_err++;
      end
    end
    bus_write(ca(1, 1), 32'h8);
    bus_write(ca(1, 0), 32'd0);
  endtask

  task automatic test_oneshot;
    logic [31:0] rd;
    bus_write(ca(2, 2), 32'd3);
    bus_write(ca(2, 1), 32'h5);
    bus_read(ca(2, 0), rd);
    n_cmp++;
    if (rd !== 32'd2) begin
      $display("FAIL oneshot_running: got %0d want 2", rd); n_err++;
    end
    repeat (12) @(negedge clk);
    n_cmp++;
    if (irq !== 1'b1) begin
      $display("FAIL oneshot_irq: got %b want 1", irq); n_err++;
    end
    bus_read(ca(2, 0), rd);
    n_cmp++;
    if (rd !== 32'd1) begin
      $display("FAIL oneshot_status_done: got %0d want 1", rd); n_err++;
    end
    bus_write(ca(2, 3), 32'hFFFF);
    bus_read(ca(2, 3), rd);
    n_cmp++;
    if (rd !== 32'd0) begin
      $display("FAIL oneshot_counter_held: got %0d want 0", rd); n_err++;
    end
    bus_write(ca(2, 0), 32'd0);
    repeat (12) @(negedge clk);
    bus_read(ca(2, 0), rd);
    n_cmp++;
    if (rd !== 32'd0) begin
      $display("FAIL oneshot_single_timeout: got %0d want 0", rd); n_err++;
    end
    n_cmp++;
    if (irq !== 1'b0) begin
      $display("FAIL oneshot_irq_after_clear: got %b want 0", irq); n_err++;
    end
  endtask

  task automatic test_prescale_snapshot;
    logic [31:0] rd;
    int cnt;
    bus_write(ga(1), 32'd3);
    bus_write(ca(0, 2), 32'd2);
    bus_write(ca(0, 1), 32'h7);
    cnt = 0;
    while (irq !== 1'b1 && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
    n_cmp++;
    if (cnt >= 60) begin
      $display("FAIL presc_first_irq: got none in %0d cycles want irq", cnt); n_err++;
    end
    for (int k = 0; k < 2; k++) begin
      bus_write(ca(0, 0), 32'd0);
      cnt = 0;
      while (irq !== 1'b1 && cnt < 40) begin
        @(negedge clk);
        cnt++;
      end
      n_cmp++;
      if (cnt != 11) begin
        $display("FAIL presc_period: got %0d want 11 (12 clocks)", cnt); n_err++;
      end
    end
    // Counter hit 0 two edges ago; by the capture edge it has ticked to 2 then 1.
    repeat (8) @(negedge clk);
    bus_write(ca(0, 3), 32'd0);
    bus_read(ca(0, 3), rd);
    n_cmp++;
    if (rd !== 32'd1) begin
      $display("FAIL presc_snapshot: got %0d want 1", rd); n_err++;
    end
    bus_write(ca(0, 1), 32'h8);
    bus_write(ca(0, 0), 32'd0);
  endtask

  task automatic test_clear_vs_event;
    logic [31:0] rd;
    bus_write(ga(1), 32'd0);
    bus_write(ca(1, 2), 32'd5);
    bus_write(ca(1, 1), 32'h7);
    repeat (5) @(negedge clk);
    bus_write(ca(1, 0), 32'd0);
    bus_read(ca(1, 0), rd);
    n_cmp++;
    if (rd !== 32'd2) begin
      $display("FAIL clear_beats_event: got %0d want 2", rd); n_err++;
    end
    n_cmp++;
    if (irq !== 1'b0) begin
      $display("FAIL clear_beats_event_irq: got %b want 0", irq); n_err++;
    end
    bus_write(ca(1, 1), 32'h8);
    bus_read(ca(1, 0), rd);
    n_cmp++;
    if (rd !== 32'd0) begin
      $display("FAIL stop_clears_running: got %0d want 0", rd); n_err++;
    end
    bus_write(ca(1, 1), 32'hC);
    bus_read(ca(1, 0), rd);
    n_cmp++;
    if (rd[1] !== 1'b1) begin
      $display("FAIL start_beats_stop: got %0d want 1", rd[1]); n_err++;
    end
    bus_read(ca(1, 1), rd);
    n_cmp++;
    if (rd !== 32'hC) begin
      $display("FAIL control_readback: got %0h want c", rd); n_err++;
    end
    bus_write(ca(1, 1), 32'h8);
    bus_write(ca(1, 0), 32'd0);
  endtask

  task automatic test_invalid;
    logic [31:0] rd;
    bus_write(ca(3, 2), 32'h1234);
    bus_write(ca(3, 1), 32'h7);
    bus_write(ca(3, 3), 32'd0);
    bus_write(ga(2), 32'd55);
    for (int w = 0; w < 4; w++) begin
      bus_read(ca(2'd3, w[1:0]), rd);
      n_cmp++;
      if (rd !== 32'd0) begin
        $display("FAIL invalid_ch_word%0d: got %0h want 0", w, rd); n_err++;
      end
    end
    bus_read(ga(2), rd);
    n_cmp++;
    if (rd !== 32'd0) begin
      $display("FAIL invalid_global_word2: got %0h want 0", rd); n_err++;
    end
    bus_read(ca(0, 2), rd);
    n_cmp++;
    if (rd !== 32'd2) begin
      $display("FAIL invalid_ch0_period: got %0d want 2", rd); n_err++;
    end
    bus_read(ca(1, 2), rd);
    n_cmp++;
    if (rd !== 32'd5) begin
      $display("FAIL invalid_ch1_period: got %0d want 5", rd); n_err++;
    end
    bus_read(ca(2, 2), rd);
    n_cmp++;
    if (rd !== 32'd3) begin
      $display("FAIL invalid_ch2_period: got %0d want 3", rd); n_err++;
    end
    bus_read(ga(1), rd);
    n_cmp++;
    if (rd !== 32'd0) begin
      $display("FAIL invalid_prescale: got %0d want 0", rd); n_err++;
    end
    bus_read(ga(0), rd);
    n_cmp++;
    if (rd !== 32'd0 || irq !== 1'b0) begin
      $display("FAIL invalid_irq_pending: got %0h/%b want 0/0", rd, irq); n_err++;
    end
  endtask

  task automatic test_reset_midcount;
    logic [31:0] rd;
    bus_write(ca(0, 2), 32'd2);
    bus_write(ca(0, 1), 32'h7);
    repeat (10) @(negedge clk);
    n_cmp++;
    if (irq !== 1'b1) begin
      $display("FAIL midreset_irq_before: got %b want 1", irq); n_err++;
    end
    bus_write(ca(0, 3), 32'd0);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (readdata !== 32'd0 || irq !== 1'b0) begin
      $display("FAIL midreset_async: got %0h/%b want 0/0", readdata, irq); n_err++;
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (irq !== 1'b0) begin
      $display("FAIL midreset_irq_after: got %b want 0", irq); n_err++;
    end
    bus_read(ca(0, 2), rd);
    n_cmp++;
    if (rd !== 32'd49999) begin
      $display("FAIL midreset_ch0_period: got %0d want 49999", rd); n_err++;
    end
    bus_read(ca(1, 2), rd);
    n_cmp++;
    if (rd !== 32'd49999) begin
      $display("FAIL midreset_ch1_period: got %0d want 49999", rd); n_err++;
    end
    bus_read(ca(0, 0), rd);
    n_cmp++;
    if (rd !== 32'd0) begin
      $display("FAIL midreset_ch0_status: got %0d want 0", rd); n_err++;
    end
    bus_read(ca(0, 1), rd);
    n_cmp++;
    if (rd !== 32'd0) begin
      $display("FAIL midreset_ch0_control: got %0d want 0", rd); n_err++;
    end
    bus_read(ca(0, 3), rd);
    n_cmp++;
    if (rd !== 32'd0) begin
      $display("FAIL midreset_ch0_snapshot: got %0d want 0", rd); n_err++;
    end
    bus_read(ga(1), rd);
    n_cmp++;
    if (rd !== 32'd7) begin
      $display("FAIL midreset_prescale: got %0d want 7", rd); n_err++;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_continuous();
    test_oneshot();
    test_prescale_snapshot();
    test_clear_vs_event();
    test_invalid();
    test_reset_midcount();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
